xps2_rxfifo: RTL
================

// Module: xps2_rxfifo
// PURPOSE
//  Memory-mapped PS/2 receiver with a parametrised byte FIFO, sticky error flags and an interrupt line.
//  Replaces the single-byte, reset-on-read PS/2 slave. The controller no longer polls a done bit per byte.
//  Sits on the controller data bus (sel/we/addr/data) behind the top-level address decoder at PS2_BASE.
//  The keyboard pins PS2_CLK/PS2_DATA connect directly to this block.
// PARAMETERS
//  DATA_W       32      data bus width (>= 16)
//  FIFO_AW      3       log2 FIFO depth; depth = 2**FIFO_AW bytes
//  SYNC_STAGES  2       flops in the PS2_CLK/PS2_DATA synchronisers (>= 2)
//  TIMEOUT_CYC  100000  clk cycles without a PS/2 falling edge mid-frame before the frame is aborted
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous, active-high reset
//  PS2_CLK   in   1        PS/2 clock, asynchronous
//  PS2_DATA  in   1        PS/2 data, asynchronous
//  sel       in   1        bus select (decoded by top level)
//  we        in   1        1 = write, 0 = read
//  addr      in   2        register offset: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//  data_in   in   DATA_W   write data
//  data_out  out  DATA_W   read data, combinational from addr; valid in the same cycle
//  irq       out  1        = enable & ~empty
// BEHAVIOUR
//  Reset: FIFO empty, count 0, all sticky flags 0, enable 1, FSM IDLE, timeout counter 0, irq 0.
//    At reset, data_out is 0 except at CTRL, where it is 1.
//  Sync: PS2_CLK and PS2_DATA each pass through SYNC_STAGES flops. fall = prev_sync_clk & ~sync_clk.
//    Data is sampled from sync_data on the cycle fall is asserted.
//  FSM IDLE: on fall with data=0 (start bit) -> RECV, bitcnt=1. A fall with data=1 is ignored.
//  FSM RECV: on each fall, shift in the bit and increment bitcnt.
//    Data bits arrive LSB first in bits 1..8, odd parity in bit 9, stop in bit 10.
//    After bit 10 -> DONE.
//  FSM RECV: timeout counter clears on every fall. When it reaches TIMEOUT_CYC-1:
//    set FERR, go to IDLE, and discard the partial byte.
//  FSM DONE (1 cycle): stop=0 -> set FERR, drop. Parity not odd -> set PERR, drop.
//    Otherwise, if enable=1, push the byte; if the FIFO is full, set OVF and drop the new byte.
//    Enable=0 drops silently. Always -> IDLE.
//  Enable=0 does not stop the FSM; frames in flight complete and are then dropped.
//  DATA read: returns {0, head[7:0]}. A sel&~we read pops the head at the clock edge.
//    A read when empty returns 0 and does not pop. Writes to DATA are ignored.
//  STATUS read: bit0 ~empty, bit1 full, bit2 OVF, bit3 PERR, bit4 FERR, bits[8 +: FIFO_AW+1] count.
//    All other bits read 0.
//  STATUS write: 1s in bits [4:2] clear the matching sticky flags.
//    If a flag is set and cleared in the same cycle, the set wins.
//  CTRL: bit0 enable (R/W). Bit1 flush, write-1 self-clearing: empties the FIFO next edge; reads as 0.
//  Simultaneous push and pop, not empty: both take effect, count unchanged. When full, the push is accepted, not OVF.
//  Simultaneous push and pop, empty: the pop is ignored (read returns 0) and the push is stored.
//  Flush in the same cycle as push or pop: flush wins, FIFO ends empty, OVF is not set.
//  Pointers are FIFO_AW bits and wrap modulo depth. count is FIFO_AW+1 bits, range 0..2**FIFO_AW.
//  Reset mid-frame: FSM returns to IDLE. The next frame is received only after a fresh start bit.
// TESTING
//  1. Send frame 0x1C (odd parity ok), read STATUS -> 0x101, irq=1.
//     Read DATA -> 0x1C. Then STATUS -> 0x000, irq=0.
//  2. Send 2**FIFO_AW+1 frames 0x01..0x09 (depth 8): STATUS full=1, OVF=1, count=8.
//     Eight DATA reads -> 0x01..0x08 in order. Write STATUS 0x04 -> OVF clears.
//  3. Send 0x5A with a wrong parity bit -> PERR=1, FIFO empty.
//     Send 0x5A with stop=0 -> FERR=1, FIFO empty.
//  4. Send a frame truncated after 5 bits, wait TIMEOUT_CYC -> FERR=1, FSM IDLE.
//     Then a good frame 0x33 -> received intact.
//  5. Fill to full; pop in the same cycle as DONE pushes 0x77 -> count stays 8, no OVF, 0x77 is at the tail.
//  6. Write CTRL=0 and send 0x44 -> dropped, irq=0.
//     Queue 3 bytes and write CTRL=0x3 -> count 0, enable 1. Assert rst mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/xps2_rxfifo.sv
// -----------------------------------------------------------------------------
// xps2_rxfifo
// Memory-mapped PS/2 receiver. Frames arriving on PS2_CLK/PS2_DATA are
// deserialised, checked (odd parity, stop bit, inter-edge timeout) and pushed
// into a byte FIFO of depth 2**FIFO_AW. Errors latch into sticky flags. An
// interrupt is raised while the receiver is enabled and the FIFO holds data.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   PS2_CLK   PS/2 clock line (asynchronous)
//   PS2_DATA  PS/2 data line (asynchronous)
//   sel       bus select from the address decoder
//   we        1 = write, 0 = read
//   addr      register offset: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   data_in   bus write data
//   data_out  bus read data, combinational from addr
//   irq       enable & ~empty
//
// Register map
//   DATA   (R)  {0, head byte}; a read pops the head (no pop when empty)
//   STATUS (R)  bit0 ~empty, bit1 full, bit2 OVF, bit3 PERR, bit4 FERR,
//               bits[8 +: FIFO_AW+1] count
//   STATUS (W)  write 1 to bits [4:2] to clear OVF/PERR/FERR
//   CTRL   (RW) bit0 enable; bit1 flush (write-1, self-clearing, reads 0)
// -----------------------------------------------------------------------------
module xps2_rxfifo #(
    parameter int DATA_W      = 32,
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. Reset to 1 (the idle level of both lines) so a
    // reset never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_clk_sync[gi] <= 1'b1;
                        r_dat_sync[gi] <= 1'b1;
                    end else begin
                        r_clk_sync[gi] <= PS2_CLK;
                        r_dat_sync[gi] <= PS2_DATA;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_clk_sync[gi] <= 1'b1;
                        r_dat_sync[gi] <= 1'b1;
                    end else begin
                        r_clk_sync[gi] <= r_clk_sync[gi-1];
                        r_dat_sync[gi] <= r_dat_sync[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_clk_prev <= 1'b1;
        else     r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end

    logic w_fall;
    logic w_bit;
    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit  = r_dat_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame receiver. The shift register collects bits 1..10 LSB first, so
    // once complete [7:0] is the byte, [8] parity and [9] stop.
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [3:0]      r_bitcnt;
    logic [9:0]      r_shift;
    logic [TO_W-1:0] r_to_cnt;

    // A fall in the same cycle as the terminal count keeps the frame alive.
    logic w_timeout;
    assign w_timeout = (r_state == S_RECV) && !w_fall &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 10'd0;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_fall && !w_bit) begin
                        r_state  <= S_RECV;
                        r_bitcnt <= 4'd1;
                    end
                end
                S_RECV: begin
                    if (w_fall) begin
                        r_to_cnt <= '0;
                        r_shift  <= {w_bit, r_shift[9:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd10) r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_to_cnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE lasts one cycle; checks and the push are decoded
                    // combinationally from the completed shift register.
                    r_to_cnt <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    logic w_done;
    logic w_stop_err;
    logic w_par_err;
    logic w_frame_ok;
    assign w_done     = (r_state == S_DONE);
    assign w_stop_err = w_done && !r_shift[9];
    assign w_par_err  = w_done && r_shift[9] && !(^r_shift[8:0]);
    assign w_frame_ok = w_done && r_shift[9] && (^r_shift[8:0]);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_rd_data;
    logic w_wr_status;
    logic w_wr_ctrl;
    logic w_flush;
    assign w_rd_data   = sel && !we && (addr == 2'd0);
    assign w_wr_status = sel &&  we && (addr == 2'd1);
    assign w_wr_ctrl   = sel &&  we && (addr == 2'd2);
    assign w_flush     = w_wr_ctrl && data_in[1];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_enable;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_ovf_set;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = w_rd_data && !w_empty && !w_flush;
    assign w_push_req = w_frame_ok && r_enable;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop) && !w_flush;
    assign w_ovf_set  = w_push_req && w_full && !w_pop && !w_flush;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control and sticky flags (a set beats a clear in the same cycle)
    // ------------------------------------------------------------------
    logic r_ovf;
    logic r_perr;
    logic r_ferr;
    logic [2:0] w_clr;
    assign w_clr = w_wr_status ? data_in[4:2] : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b1;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_enable <= data_in[0];
            r_ovf  <= (r_ovf  && !w_clr[0]) || w_ovf_set;
            r_perr <= (r_perr && !w_clr[1]) || w_par_err;
            r_ferr <= (r_ferr && !w_clr[2]) || w_stop_err || w_timeout;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        data_out = '0;
        case (addr)
            2'd0: begin
                if (!w_empty) data_out[7:0] = r_mem[r_rd_ptr];
            end
            2'd1: begin
                data_out[0]       = !w_empty;
                data_out[1]       = w_full;
                data_out[2]       = r_ovf;
                data_out[3]       = r_perr;
                data_out[4]       = r_ferr;
                data_out[8 +: CW] = r_count;
            end
            2'd2: data_out[0] = r_enable;
            default: data_out = '0;
        endcase
    end

    assign irq = r_enable && !w_empty;

    logic w_unused_bits;
    assign w_unused_bits = ^data_in[DATA_W-1:5];

endmodule
